// File: rtl/hash_table_pkg.sv
// Shared hash-table types: the lookup result word and arbiter defaults.
// Consumed by ht_res_if, ht_rr_arb and ht_res_arb.
package hash_table;

    localparam int HT_RES_ARB_STAT_W_DEFAULT = 32;

    typedef struct packed {
        logic        hit;
        logic [7:0]  tag;
        logic [31:0] data;
    } ht_result_t;

endpackage

// File: rtl/ht_res_if.sv
// Valid/ready channel carrying one ht_result_t per transfer.
// A transfer completes on a clock edge where valid and ready are both 1.
interface ht_res_if;
    import hash_table::*;

    ht_result_t result;
    logic       valid;
    logic       ready;

    modport master (output result, output valid, input ready);
    modport slave  (input result, input valid, output ready);

endinterface

// File: rtl/ht_rr_arb.sv
// Combinational round-robin pick: first requester after last_grant,
// wrapping from REQ_CNT-1 back to 0.
module ht_rr_arb #(
    parameter  int REQ_CNT = 3,
    localparam int IW      = (REQ_CNT > 1) ? $clog2(REQ_CNT) : 1
) (
    input  logic [REQ_CNT-1:0] req,
    input  logic [IW-1:0]      last_grant,
    output logic               gnt_valid,
    output logic [IW-1:0]      gnt_idx
);

    int idx;

    // Walk from farthest to nearest so the nearest requester wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        for (int k = REQ_CNT; k >= 1; k--) begin
            idx = (int'(last_grant) + k) % REQ_CNT;
            if (req[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/ht_res_arb.sv
// Round-robin merge of DIR_CNT result channels into one registered output.
// Define HT_RES_ARB_STAT_EN to build the saturating statistics counters.
module ht_res_arb
    import hash_table::*;
#(
    parameter  int DIR_CNT = 3,
    parameter  int STAT_W  = HT_RES_ARB_STAT_W_DEFAULT,
    localparam int IW      = (DIR_CNT > 1) ? $clog2(DIR_CNT) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    ht_res_if.slave           ht_res_in [DIR_CNT-1:0],
    ht_res_if.master          ht_res_out,
    output logic [IW-1:0]     grant_idx_o,
    output logic [STAT_W-1:0] fwd_cnt_o [DIR_CNT-1:0],
    output logic [STAT_W-1:0] contention_cnt_o
);

    logic [DIR_CNT-1:0] in_valid;
    logic [DIR_CNT-1:0] in_ready;
    ht_result_t         in_res [DIR_CNT-1:0];

    for (genvar g = 0; g < DIR_CNT; g++) begin : g_in
        assign in_valid[g]        = ht_res_in[g].valid;
        assign in_res[g]          = ht_res_in[g].result;
        assign ht_res_in[g].ready = in_ready[g];
    end

    logic            out_valid_q, out_valid_d;
    ht_result_t      out_res_q, out_res_d;
    logic [IW-1:0]   grant_q, grant_d;
    logic [IW-1:0]   last_q, last_d;
    logic            gnt_valid;
    logic [IW-1:0]   gnt_idx;
    logic            load_en;
    logic            accept;

    ht_rr_arb #(
        .REQ_CNT (DIR_CNT)
    ) u_rr (
        .req        (in_valid),
        .last_grant (last_q),
        .gnt_valid  (gnt_valid),
        .gnt_idx    (gnt_idx)
    );

    assign load_en = !out_valid_q || ht_res_out.ready;
    assign accept  = load_en && gnt_valid && !rst_i;

    always_comb begin
        in_ready = '0;
        for (int g = 0; g < DIR_CNT; g++) begin
            in_ready[g] = accept && (gnt_idx == IW'(g));
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_res_d   = out_res_q;
        grant_d     = grant_q;
        last_d      = last_q;
        if (load_en) begin
            out_valid_d = gnt_valid;
            if (gnt_valid) begin
                out_res_d = in_res[gnt_idx];
                grant_d   = gnt_idx;
                last_d    = gnt_idx;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            grant_q     <= '0;
            last_q      <= IW'(DIR_CNT - 1);
        end else begin
            out_valid_q <= out_valid_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
        end
    end

    // Payload is only meaningful under out_valid, so it carries no reset.
    always_ff @(posedge clk_i) begin
        out_res_q <= out_res_d;
    end

    assign ht_res_out.valid  = out_valid_q;
    assign ht_res_out.result = out_res_q;
    assign grant_idx_o       = grant_q;

`ifdef HT_RES_ARB_STAT_EN
    logic [STAT_W-1:0] fwd_q [DIR_CNT-1:0];
    logic [STAT_W-1:0] fwd_d [DIR_CNT-1:0];
    logic [STAT_W-1:0] cont_q, cont_d;
    logic              multi;

    // Clearing the lowest set bit leaves something only if two or more are set.
    assign multi = |(in_valid & (in_valid - DIR_CNT'(1)));

    always_comb begin
        for (int g = 0; g < DIR_CNT; g++) begin
            fwd_d[g] = fwd_q[g];
            if (in_ready[g] && (fwd_q[g] != '1)) begin
                fwd_d[g] = fwd_q[g] + 1'b1;
            end
        end
        cont_d = cont_q;
        if (load_en && multi && (cont_q != '1)) begin
            cont_d = cont_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int g = 0; g < DIR_CNT; g++) begin
                fwd_q[g] <= '0;
            end
            cont_q <= '0;
        end else begin
            fwd_q  <= fwd_d;
            cont_q <= cont_d;
        end
    end

    assign fwd_cnt_o        = fwd_q;
    assign contention_cnt_o = cont_q;
`else
    always_comb begin
        for (int g = 0; g < DIR_CNT; g++) begin
            fwd_cnt_o[g] = '0;
        end
        contention_cnt_o = '0;
    end
`endif

endmodule

// File: tb/tb_ht_res_arb.sv
// Bench for ht_res_arb: a 3-source instance under directed then random traffic,
// and a 1-source instance under random traffic against a queue scoreboard.
module tb_ht_res_arb;
    import hash_table::*;

    localparam int N   = 3;
    localparam int SW  = 4;
    localparam int SAT = (1 << SW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    ht_res_if in3 [N-1:0] ();
    ht_res_if out3 ();
    ht_res_if in1 [0:0] ();
    ht_res_if out1 ();

    logic [N-1:0] v3, rdy3;
    ht_result_t   w3 [N];
    logic         ordy3;
    logic [1:0]   gi3;
    logic [SW-1:0] f3 [N-1:0];
    logic [SW-1:0] c3;

    logic          v1, rdy1, ordy1;
    ht_result_t    w1;
    logic          gi1;
    logic [SW-1:0] f1 [0:0];
    logic [SW-1:0] c1;

    for (genvar g = 0; g < N; g++) begin : g_in
        assign in3[g].valid  = v3[g];
        assign in3[g].result = w3[g];
        assign rdy3[g]       = in3[g].ready;
    end
    assign in1[0].valid  = v1;
    assign in1[0].result = w1;
    assign rdy1          = in1[0].ready;
    assign out3.ready    = ordy3;
    assign out1.ready    = ordy1;

    ht_res_arb #(.DIR_CNT(N), .STAT_W(SW)) dut3 (
        .clk_i            (clk),
        .rst_i            (rst),
        .ht_res_in        (in3),
        .ht_res_out       (out3),
        .grant_idx_o      (gi3),
        .fwd_cnt_o        (f3),
        .contention_cnt_o (c3)
    );

    ht_res_arb #(.DIR_CNT(1), .STAT_W(SW)) dut1 (
        .clk_i            (clk),
        .rst_i            (rst),
        .ht_res_in        (in1),
        .ht_res_out       (out1),
        .grant_idx_o      (gi1),
        .fwd_cnt_o        (f1),
        .contention_cnt_o (c1)
    );

    int n_chk = 0;
    int n_err = 0;
    int seq   = 0;
    bit rand_mode = 1'b0;

    // reference state for the 3-source instance
    bit         m_ov;
    ht_result_t m_w;
    int         m_idx, m_lg, m_cont;
    int         m_fwd [N];
    int         waits [N];
    bit         le;
    int         pick;
    logic [N-1:0] e_rdy;

    // reference state for the 1-source instance
    ht_result_t q1 [$];
    int         m1_fwd;
    bit         e1;

    ht_result_t hold;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic ht_result_t rnd_word();
        ht_result_t w;
        w.hit  = 1'($urandom);
        w.tag  = 8'($urandom);
        w.data = 32'(seq);
        seq++;
        return w;
    endfunction

    task automatic predict();
        le    = !m_ov || ordy3;
        pick  = -1;
        e_rdy = '0;
        if (!rst && le) begin
            for (int k = 1; k <= N; k++) begin
                if (pick < 0 && v3[(m_lg + k) % N]) pick = (m_lg + k) % N;
            end
        end
        if (pick >= 0) e_rdy[pick] = 1'b1;
        e1 = !rst && v1 && (q1.size() == 0 || ordy1);
    endtask

    task automatic check_outs();
        chk("rdy3", 64'(rdy3), 64'(e_rdy));
        chk("ov3", 64'(out3.valid), 64'(m_ov));
        if (m_ov) chk("data3", 64'(out3.result), 64'(m_w));
        chk("gidx3", 64'(gi3), 64'(m_idx));
        chk("rdy1", 64'(rdy1), 64'(e1));
        chk("ov1", 64'(out1.valid), 64'(q1.size() != 0));
        if (q1.size() != 0) chk("data1", 64'(out1.result), 64'(q1[0]));
        chk("gidx1", 64'(gi1), 64'(0));
`ifdef HT_RES_ARB_STAT_EN
        for (int s = 0; s < N; s++) chk("fwd3", 64'(f3[s]), 64'(m_fwd[s]));
        chk("cont3", 64'(c3), 64'(m_cont));
        chk("fwd1", 64'(f1[0]), 64'(m1_fwd));
`else
        for (int s = 0; s < N; s++) chk("fwd3", 64'(f3[s]), 64'(0));
        chk("cont3", 64'(c3), 64'(0));
        chk("fwd1", 64'(f1[0]), 64'(0));
`endif
        chk("cont1", 64'(c1), 64'(0));
    endtask

    task automatic commit();
        if (rst) begin
            m_ov = 1'b0; m_lg = N - 1; m_idx = 0; m_cont = 0;
            for (int s = 0; s < N; s++) begin m_fwd[s] = 0; waits[s] = 0; end
            q1.delete();
            m1_fwd = 0;
            return;
        end
        if (le) begin
            if ($countones(v3) >= 2 && m_cont < SAT) m_cont++;
            if (pick >= 0) begin
                for (int s = 0; s < N; s++) begin
                    if (!v3[s]) waits[s] = 0;
                    else if (s != pick) waits[s]++;
                end
                chk("fair", 64'(waits[pick] < N), 64'(1));
                waits[pick] = 0;
                m_ov = 1'b1; m_w = w3[pick]; m_idx = pick; m_lg = pick;
                if (m_fwd[pick] < SAT) m_fwd[pick]++;
            end else begin
                m_ov = 1'b0;
            end
        end
        if (q1.size() != 0 && ordy1) void'(q1.pop_front());
        if (e1) begin
            q1.push_back(w1);
            if (m1_fwd < SAT) m1_fwd++;
        end
    endtask

    task automatic refresh();
        if (pick >= 0 && !rst) begin
            w3[pick] = rnd_word();
            if (rand_mode) v3[pick] = 1'($urandom);
        end
        if (rand_mode) begin
            for (int s = 0; s < N; s++) if (!v3[s]) v3[s] = 1'($urandom);
            ordy3 = ($urandom % 3) != 0;
        end
        if (e1) begin
            w1 = rnd_word();
            v1 = 1'($urandom);
        end else if (!v1) begin
            v1 = 1'($urandom);
        end
        ordy1 = ($urandom % 4) != 0;
    endtask

    task automatic cyc();
        @(negedge clk);
        predict();
        check_outs();
        @(posedge clk);
        #1;
        commit();
        refresh();
    endtask

    initial begin
        rst = 1'b1; v3 = 3'b111; ordy3 = 1'b1;
        v1 = 1'b0; ordy1 = 1'b1; w1 = rnd_word();
        for (int s = 0; s < N; s++) w3[s] = rnd_word();
        @(posedge clk); #1;
        commit();
        cyc(); cyc();

        // reset values, then round-robin with every source valid
        rst = 1'b0;
        chk("rst_ov", 64'(out3.valid), 64'(0));
        chk("rst_gidx", 64'(gi3), 64'(0));
        chk("rst_cont", 64'(c3), 64'(0));
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("rr_ov", 64'(out3.valid), 64'(1));
            chk("rr_seq", 64'(gi3), 64'(i % 3));
        end

        // only source 2, output stalled for 5 cycles
        v3 = 3'b100;
        cyc();
        ordy3 = 1'b0;
        hold = out3.result;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("stall_gidx", 64'(gi3), 64'(2));
            chk("stall_data", 64'(out3.result), 64'(hold));
            chk("stall_rdy", 64'(rdy3), 64'(0));
        end
        ordy3 = 1'b1;
        #1;
        chk("release_rdy", 64'(rdy3), 64'(3'b100));
        cyc();

        // after grant to 1, source 0 precedes source 1
        v3 = 3'b010;
        cyc();
        chk("g1", 64'(gi3), 64'(1));
        v3 = 3'b011;
        cyc();
        chk("g1_then0", 64'(gi3), 64'(0));
        cyc();
        chk("g0_then1", 64'(gi3), 64'(1));

        // reset while holding a word
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("mid_rst_ov", 64'(out3.valid), 64'(0));
        chk("mid_rst_cont", 64'(c3), 64'(0));
        chk("mid_rst_fwd0", 64'(f3[0]), 64'(0));
        v3 = 3'b111;
        cyc();
        chk("post_rst_g0", 64'(gi3), 64'(0));

        // contention saturation
        for (int i = 0; i < 20; i++) cyc();
`ifdef HT_RES_ARB_STAT_EN
        chk("cont_sat", 64'(c3), 64'(SAT));
`else
        chk("cont_off", 64'(c3), 64'(0));
`endif

        rand_mode = 1'b1;
        for (int i = 0; i < 1000; i++) cyc();
        chk("drain1_order", 64'(q1.size() <= 1), 64'(1));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/ht_res_arb.md
HT_RES_ARB -- requirements
Module: ht_res_arb

Interface
REQ-001 Parameter DIR_CNT, default 3, number of result sources (1..16).
REQ-002 Parameter STAT_W, default 32, width of each statistics counter.
REQ-003 clk_i  input  1  system clock; single clock domain.
REQ-004 rst_i  input  1  reset; synchronous and active-high.
REQ-005 ht_res_in[DIR_CNT-1:0]  ht_res_if.slave  per-source result (ht_result_t), valid, ready.
REQ-006 ht_res_out  ht_res_if.master  arbitrated result, valid, ready.
REQ-007 grant_idx_o  output  $clog2(DIR_CNT) (min 1)  source index of the word currently held in the output register.
REQ-008 fwd_cnt_o[DIR_CNT-1:0]  output  STAT_W each  per-source count of results accepted.
REQ-009 contention_cnt_o  output  STAT_W  count of cycles with more than one source valid while the block was able to accept.

Function
REQ-010 The block SHALL hold one output register (result, valid, source index) driving ht_res_out and grant_idx_o.
REQ-011 load_en = !out_valid || ht_res_out.ready; the block SHALL accept at most one input per cycle, and only when load_en=1.
REQ-012 Arbitration SHALL be round-robin: search starts at last_grant+1 modulo DIR_CNT and picks the first source with valid=1.
REQ-013 ht_res_in[g].ready SHALL be 1 only when load_en=1 and g is the picked source; all other readys are 0, combinationally.
REQ-014 On acceptance, the output register SHALL load the source's result on the next clock edge, with out_valid=1 and last_grant=g; latency in-valid to out-valid is 1 cycle.
REQ-015 If load_en=1 and no source is valid, out_valid SHALL go to 0 on the next edge and last_grant SHALL be unchanged.
REQ-016 While out_valid=1 and ht_res_out.ready=0, the output result and grant_idx_o SHALL be held stable and no input SHALL be accepted.
REQ-017 Sustained throughput SHALL be one result per cycle when ht_res_out.ready=1 continuously.
REQ-018 No input word SHALL be dropped or duplicated; every source with valid held high SHALL be granted within DIR_CNT accepted transfers.
REQ-019 The last_grant pointer SHALL wrap from DIR_CNT-1 to 0.
REQ-020 With DIR_CNT=1, the block SHALL reduce to a one-entry pipeline register with identical handshake behaviour.

Reset
REQ-021 On rst_i=1 at a clock edge, out_valid SHALL be 0, last_grant SHALL be DIR_CNT-1 (source 0 has first priority), grant_idx_o SHALL be 0, and all counters SHALL be 0.
REQ-022 During reset, all input readys SHALL be 0.
REQ-023 Reset asserted mid-transfer SHALL discard the held word; there is no replay.
REQ-024 The output result payload is not reset; it is don't-care while out_valid=0.

Configuration
REQ-025 Macro HT_RES_ARB_STAT_EN defined: fwd_cnt_o increments per accepted word of its source, and contention_cnt_o increments per cycle with load_en=1 and two or more sources valid; both saturate at all-ones.
REQ-026 Macro HT_RES_ARB_STAT_EN undefined: no counter logic is instantiated, and the statistics ports SHALL be tied to 0 while remaining present.

Structure
REQ-027 ht_result_t stays in package hash_table, and the package SHALL gain constant HT_RES_ARB_STAT_W_DEFAULT = 32.
REQ-028 The round-robin search SHALL be a combinational sub-module ht_rr_arb (parameters REQ_CNT; inputs req, last_grant; outputs gnt_valid, gnt_idx), reusable by other arbiters.

Verification
REQ-029 After reset, sources 0,1,2 are all valid continuously with out ready=1 -> outputs from sources 0,1,2,0,1,2 on consecutive cycles, first output one cycle after the first accept.
REQ-030 Only source 2 is valid, and out ready is held at 0 for 5 cycles -> output is stable with grant_idx_o=2, all readys are 0, and the word is released on the first ready=1 cycle.
REQ-031 Source 1 is valid after source 1 was the last grant, and source 0 is also valid -> source 0 is granted next, and source 1 follows.
REQ-032 rst_i is pulsed while out_valid=1 -> the next cycle has out_valid=0 and all counters are 0, and the following grant goes to source 0.
REQ-033 With HT_RES_ARB_STAT_EN defined and STAT_W=4, 20 contending cycles -> contention_cnt_o saturates at 15; without the macro, all statistics outputs read 0.
REQ-034 With DIR_CNT=1 and random valid/ready for 1000 cycles -> a scoreboard shows output equals input in order with no loss.
